// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, x/y counters, registered syncs, video_on and line/frame strobes.
// All outputs change one clk after the divider reaches its last count; free-running, no backpressure.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter logic        SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pixel_tick,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       line_start,
   output logic       frame_start
);

   // CLK_DIV=1 still needs a one-bit divider register that simply stays at zero.
   localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
   localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0] H_LAST = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
   localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);
   localparam logic [9:0] V_LAST = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       x_q, x_d, y_q, y_d;
   logic             pixel_tick_q, pixel_tick_d;
   logic             video_on_q, video_on_d;
   logic             hsync_q, hsync_d, vsync_q, vsync_d;
   logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
   logic             tick, x_wrap, y_wrap;

   always_comb begin
      tick          = (div_q == DIV_LAST);
      x_wrap        = (x_q == H_LAST);
      y_wrap        = (y_q == V_LAST);
      div_d         = tick ? '0 : div_q + DIV_W'(1);
      x_d           = x_q;
      y_d           = y_q;
      video_on_d    = video_on_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      pixel_tick_d  = tick;
      line_start_d  = tick & x_wrap;
      frame_start_d = tick & x_wrap & y_wrap;
      if (tick) begin
         x_d = x_wrap ? 10'd0 : x_q + 10'd1;
         if (x_wrap) begin
            y_d = y_wrap ? 10'd0 : y_q + 10'd1;
         end
         // Decode from the next counter values so syncs/video_on align with x/y.
         video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
         hsync_d    = ((x_d >= HS_BEG) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
         vsync_d    = ((y_d >= VS_BEG) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q         <= '0;
         x_q           <= 10'd0;
         y_q           <= 10'd0;
         pixel_tick_q  <= 1'b0;
         video_on_q    <= 1'b1;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         x_q           <= x_d;
         y_q           <= y_d;
         pixel_tick_q  <= pixel_tick_d;
         video_on_q    <= video_on_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pixel_tick  = pixel_tick_q;
   assign x           = x_q;
   assign y           = y_q;
   assign video_on    = video_on_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance (CLK_DIV=4), a CLK_DIV=1 instance, and a 15x10 raster
// at CLK_DIV=2 in both sync polarities so full frames fit in a short run.
module tb_vga_timing_gen;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;

   initial forever #5 clk = ~clk;

   logic       d_tk, d_von, d_hs, d_vs, d_ls, d_fs;
   logic [9:0] d_x, d_y;
   logic       o_tk, o_von, o_hs, o_vs, o_ls, o_fs;
   logic [9:0] o_x, o_y;
   logic       s_tk, s_von, s_hs, s_vs, s_ls, s_fs;
   logic [9:0] s_x, s_y;
   logic       p_tk, p_von, p_hs, p_vs, p_ls, p_fs;
   logic [9:0] p_x, p_y;

   vga_timing_gen u_def (
      .clk(clk), .rst_n(rst_n), .pixel_tick(d_tk), .x(d_x), .y(d_y), .video_on(d_von),
      .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs));

   vga_timing_gen #(.CLK_DIV(1)) u_div1 (
      .clk(clk), .rst_n(rst_n), .pixel_tick(o_tk), .x(o_x), .y(o_y), .video_on(o_von),
      .hsync(o_hs), .vsync(o_vs), .line_start(o_ls), .frame_start(o_fs));

   // Small raster: hsync on x=10..12, vsync on y=7..8, 150 ticks / 300 clks per frame.
   vga_timing_gen #(.CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0)) u_sm (
      .clk(clk), .rst_n(rst_n), .pixel_tick(s_tk), .x(s_x), .y(s_y), .video_on(s_von),
      .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs));

   vga_timing_gen #(.CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)) u_smp (
      .clk(clk), .rst_n(rst_n), .pixel_tick(p_tk), .x(p_x), .y(p_y), .video_on(p_von),
      .hsync(p_hs), .vsync(p_vs), .line_start(p_ls), .frame_start(p_fs));

   task automatic reset_release();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (d_x !== 10'd0 || d_y !== 10'd0) begin
         errors++; $display("FAIL reset_xy: got x=%0d y=%0d, expected 0 0", d_x, d_y);
      end
      checks++;
      if (d_von !== 1'b1) begin
         errors++; $display("FAIL reset_video_on: got %b, expected 1", d_von);
      end
      checks++;
      if (d_hs !== 1'b1 || d_vs !== 1'b1) begin
         errors++; $display("FAIL reset_sync: got hs=%b vs=%b, expected 1 1", d_hs, d_vs);
      end
      checks++;
      if (d_tk !== 1'b0 || d_ls !== 1'b0 || d_fs !== 1'b0) begin
         errors++; $display("FAIL reset_strobes: got tick=%b ls=%b fs=%b, expected 0 0 0", d_tk, d_ls, d_fs);
      end
      checks++;
      if (p_hs !== 1'b0 || p_vs !== 1'b0) begin
         errors++; $display("FAIL reset_sync_pol1: got hs=%b vs=%b, expected 0 0", p_hs, p_vs);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_divider();
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         checks++;
         if (d_tk !== ((k % 4) == 0)) begin
            errors++; $display("FAIL div4_tick clk %0d: got %b, expected %b", k, d_tk, (k % 4) == 0);
         end
         checks++;
         if (d_x !== 10'(k / 4)) begin
            errors++; $display("FAIL div4_x clk %0d: got %0d, expected %0d", k, d_x, k / 4);
         end
         checks++;
         if (o_tk !== 1'b1 || o_x !== 10'(k)) begin
            errors++; $display("FAIL div1 clk %0d: got tick=%b x=%0d, expected 1 %0d", k, o_tk, o_x, k);
         end
      end
   endtask

   task automatic test_line();
      int hs_low = 0;
      int viol = 0;
      bit wrapped = 1'b0;
      logic [9:0] px = d_x;
      for (int k = 0; k < 4000 && !wrapped; k++) begin
         @(negedge clk);
         if (d_tk) begin
            if (d_x == 10'd0) begin
               wrapped = 1'b1;
               checks++;
               if (d_ls !== 1'b1 || d_fs !== 1'b0 || d_y !== 10'd1) begin
                  errors++; $display("FAIL line_wrap: got ls=%b fs=%b y=%0d, expected 1 0 1", d_ls, d_fs, d_y);
               end
            end else begin
               if (d_x !== px + 10'd1 || d_ls || d_fs) viol++;
               if (d_hs == 1'b0) hs_low++;
               case (d_x)
                  10'd639: begin checks++; if (d_von !== 1'b1) begin errors++; $display("FAIL von_639: got %b, expected 1", d_von); end end
                  10'd640: begin checks++; if (d_von !== 1'b0) begin errors++; $display("FAIL von_640: got %b, expected 0", d_von); end end
                  10'd655: begin checks++; if (d_hs !== 1'b1) begin errors++; $display("FAIL hs_655: got %b, expected 1", d_hs); end end
                  10'd656: begin checks++; if (d_hs !== 1'b0) begin errors++; $display("FAIL hs_656: got %b, expected 0", d_hs); end end
                  10'd751: begin checks++; if (d_hs !== 1'b0) begin errors++; $display("FAIL hs_751: got %b, expected 0", d_hs); end end
                  10'd752: begin checks++; if (d_hs !== 1'b1) begin errors++; $display("FAIL hs_752: got %b, expected 1", d_hs); end end
                  default: ;
               endcase
            end
         end else if (d_x !== px || d_ls || d_fs) begin
            viol++;
         end
         px = d_x;
      end
      checks++;
      if (!wrapped) begin
         errors++; $display("FAIL line_timeout: got no wrap, expected wrap within 4000 clks");
      end
      checks++;
      if (hs_low != 96) begin
         errors++; $display("FAIL hsync_width: got %0d ticks, expected 96", hs_low);
      end
      checks++;
      if (viol != 0) begin
         errors++; $display("FAIL line_step_hold: got %0d violations, expected 0", viol);
      end
   endtask

   task automatic test_first_frame();
      int first_ls = 0;
      int n_ls = 0;
      int fs_k = 0;
      reset_release();
      for (int k = 1; k <= 1000 && fs_k == 0; k++) begin
         @(negedge clk);
         if (s_ls) begin
            if (first_ls == 0) first_ls = k;
            n_ls++;
         end
         if (s_fs) fs_k = k;
      end
      checks++;
      if (first_ls != 30) begin
         errors++; $display("FAIL first_line_start: got clk %0d, expected 30", first_ls);
      end
      checks++;
      if (fs_k != 300) begin
         errors++; $display("FAIL first_frame_start: got clk %0d, expected 300", fs_k);
      end
      checks++;
      if (n_ls != 10) begin
         errors++; $display("FAIL first_frame_lines: got %0d, expected 10", n_ls);
      end
   endtask

   task automatic test_frame();
      int clks = 0, ticks = 0, n_ls = 0, n_fs = 0;
      int vs_low = 0, von = 0, von_bad = 0, hs_low = 0, pdiff = 0, p_hs_hi = 0, p_vs_hi = 0;
      int vs_min = 1023, vs_max = -1;
      logic [9:0] px = 10'd0, py = 10'd0;
      bit found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         @(negedge clk);
         found = s_fs;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL frame_sync_timeout: got no frame_start, expected one within 400 clks");
      end
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         @(negedge clk);
         clks++;
         if (p_x !== s_x || p_y !== s_y || p_tk !== s_tk || p_von !== s_von || p_ls !== s_ls ||
             p_fs !== s_fs || p_hs !== ~s_hs || p_vs !== ~s_vs) pdiff++;
         if (s_ls) n_ls++;
         if (s_tk) begin
            ticks++;
            if (s_hs == 1'b0) hs_low++;
            if (p_hs == 1'b1) p_hs_hi++;
            if (p_vs == 1'b1) p_vs_hi++;
            if (s_von) von++;
            if (s_von && s_y >= 10'd6) von_bad++;
            if (s_vs == 1'b0) begin
               vs_low++;
               if (int'(s_y) < vs_min) vs_min = int'(s_y);
               if (int'(s_y) > vs_max) vs_max = int'(s_y);
            end
         end
         if (s_fs) begin
            n_fs++;
            found = 1'b1;
            checks++;
            if (px !== 10'd14 || py !== 10'd9 || s_x !== 10'd0 || s_y !== 10'd0 || s_ls !== 1'b1) begin
               errors++; $display("FAIL frame_wrap: got (%0d,%0d)->(%0d,%0d) ls=%b, expected (14,9)->(0,0) ls=1",
                                  px, py, s_x, s_y, s_ls);
            end
         end
         px = s_x;
         py = s_y;
      end
      checks++;
      if (clks != 300 || ticks != 150) begin
         errors++; $display("FAIL frame_period: got %0d clks %0d ticks, expected 300 150", clks, ticks);
      end
      checks++;
      if (n_ls != 10 || n_fs != 1) begin
         errors++; $display("FAIL frame_strobes: got ls=%0d fs=%0d, expected 10 1", n_ls, n_fs);
      end
      checks++;
      if (vs_low != 30 || vs_min != 7 || vs_max != 8) begin
         errors++; $display("FAIL vsync_window: got %0d ticks y=%0d..%0d, expected 30 ticks y=7..8", vs_low, vs_min, vs_max);
      end
      checks++;
      if (hs_low != 30) begin
         errors++; $display("FAIL hsync_frame: got %0d ticks, expected 30", hs_low);
      end
      checks++;
      if (von != 48 || von_bad != 0) begin
         errors++; $display("FAIL video_on_frame: got %0d on, %0d in blank lines, expected 48 0", von, von_bad);
      end
      checks++;
      if (pdiff != 0 || p_hs_hi != 30 || p_vs_hi != 30) begin
         errors++; $display("FAIL sync_pol1: got %0d diffs hs_hi=%0d vs_hi=%0d, expected 0 30 30", pdiff, p_hs_hi, p_vs_hi);
      end
   endtask

   task automatic test_mid_reset();
      reset_release();
      repeat (1253) @(negedge clk);
      checks++;
      if (d_x !== 10'd313 || s_x !== 10'd11 || s_y !== 10'd1 || s_hs !== 1'b0) begin
         errors++; $display("FAIL mid_position: got def x=%0d sm (%0d,%0d) hs=%b, expected 313 (11,1) 0",
                            d_x, s_x, s_y, s_hs);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (d_x !== 10'd0 || d_y !== 10'd0 || d_von !== 1'b1 || d_hs !== 1'b1 || d_tk !== 1'b0) begin
         errors++; $display("FAIL async_reset_def: got x=%0d y=%0d von=%b hs=%b tick=%b, expected 0 0 1 1 0",
                            d_x, d_y, d_von, d_hs, d_tk);
      end
      checks++;
      if (s_x !== 10'd0 || s_y !== 10'd0 || s_hs !== 1'b1 || p_hs !== 1'b0) begin
         errors++; $display("FAIL async_reset_sm: got (%0d,%0d) hs=%b pol1_hs=%b, expected (0,0) 1 0",
                            s_x, s_y, s_hs, p_hs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (d_x !== 10'd1 || d_tk !== 1'b1 || s_x !== 10'd2) begin
         errors++; $display("FAIL restart: got def x=%0d tick=%b sm x=%0d, expected 1 1 2", d_x, d_tk, s_x);
      end
   endtask

   initial begin
      test_reset();
      test_divider();
      test_line();
      test_first_frame();
      test_frame();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
